// File: rtl/maple_tx_sequencer_if.sv
// rtl/maple_tx_sequencer_if.sv - Maple TX sequencer request/byte stream and pin bundle
interface maple_tx_sequencer_if;
  logic       start;
  logic [1:0] port_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       out_p1;
  logic       out_p5;
  logic       oe;
  logic [1:0] port_select;
  logic       busy;
  logic       done;
  logic       underrun;

  modport master (
    output start, port_in, tx_data, tx_valid, tx_last,
    input  tx_ready, out_p1, out_p5, oe, port_select, busy, done, underrun
  );

  modport slave (
    input  start, port_in, tx_data, tx_valid, tx_last,
    output tx_ready, out_p1, out_p5, oe, port_select, busy, done, underrun
  );
endinterface

// File: rtl/maple_tx_sequencer.sv
// rtl/maple_tx_sequencer.sv - Maple bus frame transmitter: lead, start pattern, bytes, end pattern
// Each bus step holds its pin levels for PHASE_CLKS clocks; FETCH is a lone undriven cycle.
module maple_tx_sequencer #(
  parameter int PHASE_CLKS = 10
) (
  input  logic                clk,
  input  logic                rst,
  maple_tx_sequencer_if.slave bus
);
  localparam logic [7:0] STEP_LAST = 8'(PHASE_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_START, S_FETCH, S_DATA, S_END, S_HOLD
  } state_t;

  state_t     r_state, w_state_nx;
  logic [7:0] r_step_cnt;
  logic [3:0] r_step_idx;
  logic [7:0] r_byte;
  logic       r_last;
  logic [1:0] r_port;
  logic       w_timed, w_step_end, w_bit;
  logic [2:0] w_bit_sel;
  logic       w_p1, w_p5, w_oe;

  assign w_timed    = r_state inside {S_LEAD, S_START, S_DATA, S_END, S_HOLD};
  assign w_step_end = w_timed && (r_step_cnt == STEP_LAST);
  // Two DATA steps per bit, MSB first.
  assign w_bit_sel  = 3'd7 - r_step_idx[3:1];
  assign w_bit      = r_byte[w_bit_sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_step_cnt <= 8'd0;
      r_step_idx <= 4'd0;
      r_byte     <= 8'd0;
      r_last     <= 1'b0;
      r_port     <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      if (w_state_nx != r_state || !w_timed) begin
        r_step_cnt <= 8'd0;
        r_step_idx <= 4'd0;
      end else if (w_step_end) begin
        r_step_cnt <= 8'd0;
        r_step_idx <= r_step_idx + 4'd1;
      end else begin
        r_step_cnt <= r_step_cnt + 8'd1;
      end
      if (r_state == S_IDLE && bus.start)
        r_port <= bus.port_in;
      if (r_state == S_FETCH && bus.tx_valid) begin
        r_byte <= bus.tx_data;
        r_last <= bus.tx_last;
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_p1       = 1'b1;
    w_p5       = 1'b1;
    w_oe       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_oe = 1'b0;
        if (bus.start) w_state_nx = S_LEAD;
      end
      S_LEAD: begin
        if (w_step_end) w_state_nx = S_START;
      end
      S_START: begin
        if (r_step_idx != 4'd9) begin
          w_p1 = 1'b0;
          w_p5 = ~r_step_idx[0];
        end
        if (w_step_end && r_step_idx == 4'd9) w_state_nx = S_FETCH;
      end
      S_FETCH: begin
        w_oe       = 1'b0;
        w_state_nx = bus.tx_valid ? S_DATA : S_END;
      end
      S_DATA: begin
        // Odd bit index toggles pin1 with data on pin5; even index is the mirror.
        if (!r_step_idx[1]) begin
          w_p1 = ~r_step_idx[0];
          w_p5 = w_bit;
        end else begin
          w_p1 = w_bit;
          w_p5 = ~r_step_idx[0];
        end
        if (w_step_end && r_step_idx == 4'd15) w_state_nx = r_last ? S_END : S_FETCH;
      end
      S_END: begin
        if (r_step_idx != 4'd5) begin
          w_p1 = ~r_step_idx[0];
          w_p5 = 1'b0;
        end
        if (w_step_end && r_step_idx == 4'd5) w_state_nx = S_HOLD;
      end
      S_HOLD: begin
        w_oe = 1'b0;
        if (w_step_end) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.out_p1      = w_p1;
  assign bus.out_p5      = w_p5;
  assign bus.oe          = w_oe;
  assign bus.port_select = r_port;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.tx_ready    = (r_state == S_FETCH) && bus.tx_valid && !rst;
  assign bus.underrun    = (r_state == S_FETCH) && !bus.tx_valid && !rst;
  assign bus.done        = (r_state == S_HOLD) && w_step_end && !rst;
endmodule

// File: tb/tb_maple_tx_sequencer.sv
// tb/tb_maple_tx_sequencer.sv - randomized frame bench against a step-table reference model
module tb_maple_tx_sequencer;
  localparam int P      = 4;
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected driven pin levels {p1,p5}, one entry per clock while oe is high.
  function automatic void build(input logic [7:0] bytes[$], input int p, output logic [1:0] q[$]);
    logic [1:0] st[$];
    logic [7:0] by;
    logic       b;
    st.push_back(2'b11);
    for (int k = 0; k < 9; k++) st.push_back((k % 2 == 0) ? 2'b01 : 2'b00);
    st.push_back(2'b11);
    foreach (bytes[n]) begin
      by = bytes[n];
      for (int i = 7; i >= 0; i--) begin
        b = by[i];
        if (i % 2 == 1) begin st.push_back({1'b1, b}); st.push_back({1'b0, b}); end
        else            begin st.push_back({b, 1'b1}); st.push_back({b, 1'b0}); end
      end
    end
    for (int k = 0; k < 5; k++) st.push_back((k % 2 == 0) ? 2'b10 : 2'b00);
    st.push_back(2'b11);
    q.delete();
    foreach (st[s]) for (int r = 0; r < p; r++) q.push_back(st[s]);
  endfunction

  maple_tx_sequencer_if bus();
  maple_tx_sequencer #(.PHASE_CLKS(P)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  logic [1:0] got_q[$];
  int         ready_t[$];
  int         ready_n = 0, done_n = 0, unr_n = 0, both_n = 0, cyc = 0;
  logic [7:0] tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.oe) got_q.push_back({bus.out_p1, bus.out_p5});
    if (bus.tx_ready) begin ready_t.push_back(cyc); ready_n++; end
    if (bus.done) done_n++;
    if (bus.underrun) unr_n++;
    if (bus.tx_ready && bus.underrun) both_n++;
  end

  task automatic drive_tx();
    bus.tx_valid = (tx_q.size() != 0);
    bus.tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    bus.tx_last  = (tx_q.size() == 1);
  endtask

  task automatic frame_test(input string tag, input logic [1:0] port, input int kick_at);
    logic [7:0] sent[$];
    logic [1:0] e[$];
    logic [1:0] lv;
    logic [7:0] dec;
    int g0, r0, rc, d0, u0, n, mism, idx;
    sent = tx_q;
    g0 = got_q.size(); r0 = ready_n; rc = ready_n; d0 = done_n; u0 = unr_n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.port_in = port; drive_tx();
    @(posedge clk); #1;
    bus.start = 1'b0; bus.port_in = 2'd0;
    n = 0;
    while (done_n == d0 && n < BUDGET) begin
      if (ready_n > rc) begin void'(tx_q.pop_front()); rc++; end
      drive_tx();
      bus.start   = (n == kick_at);
      bus.port_in = (n == kick_at) ? 2'd3 : 2'd0;
      if (n == 2) check({tag, "_busy"}, bus.busy, 1);
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({tag, "_done"}, done_n - d0, 1);
    check({tag, "_port"}, bus.port_select, port);
    check({tag, "_ready_n"}, ready_n - r0, sent.size());
    check({tag, "_underrun_n"}, unr_n - u0, (sent.size() == 0) ? 1 : 0);
    build(sent, P, e);
    check({tag, "_oe_cycles"}, got_q.size() - g0, e.size());
    mism = 0;
    for (int i = 0; i < e.size(); i++)
      if (g0 + i >= got_q.size() || got_q[g0 + i] !== e[i]) mism++;
    check({tag, "_pin_mismatches"}, mism, 0);
    for (int k = 0; k < sent.size(); k++) begin
      dec = 8'h00;
      for (int i = 7; i >= 0; i--) begin
        idx = g0 + 11 * P + k * 16 * P + (7 - i) * 2 * P;
        lv  = (idx < got_q.size()) ? got_q[idx] : 2'bxx;
        dec[i] = (i % 2 == 1) ? lv[0] : lv[1];
      end
      check($sformatf("%s_byte%0d", tag, k), dec, sent[k]);
      if (k > 0 && r0 + k < ready_t.size())
        check($sformatf("%s_gap%0d", tag, k), ready_t[r0 + k] - ready_t[r0 + k - 1], 16 * P + 1);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_w
    localparam int PW = (g == 0) ? 2 : 255;
    logic       wrst;
    logic       w_fin = 1'b0;
    int         wdone = 0;
    logic [1:0] wq[$];
    maple_tx_sequencer_if wbus();
    maple_tx_sequencer #(.PHASE_CLKS(PW)) u_w (.clk(clk), .rst(wrst), .bus(wbus));

    always @(negedge clk) begin
      if (wbus.oe) wq.push_back({wbus.out_p1, wbus.out_p5});
      if (wbus.done) wdone++;
    end

    initial begin
      logic [1:0] e[$];
      logic [7:0] b[$];
      int n, mism;
      wrst = 1'b1; wbus.start = 1'b0; wbus.port_in = 2'(g);
      wbus.tx_valid = 1'b1; wbus.tx_last = 1'b1; wbus.tx_data = 8'($urandom);
      b.push_back(wbus.tx_data);
      repeat (2) @(posedge clk);
      #1 wrst = 1'b0;
      @(posedge clk); #1 wbus.start = 1'b1;
      @(posedge clk); #1 wbus.start = 1'b0;
      n = 0;
      while (wdone == 0 && n < 20000) begin @(posedge clk); n++; end
      #1;
      check($sformatf("w%0d_done", PW), wdone, 1);
      build(b, PW, e);
      check($sformatf("w%0d_oe_cycles", PW), wq.size(), e.size());
      mism = 0;
      for (int i = 0; i < e.size(); i++) if (i >= wq.size() || wq[i] !== e[i]) mism++;
      check($sformatf("w%0d_pin_mismatches", PW), mism, 0);
      w_fin = 1'b1;
    end
  end

  initial begin
    int g0, r0, d0, u0, n, nb;
    rst = 1'b1;
    bus.start = 1'b0; bus.port_in = 2'd0;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.tx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.oe, bus.out_p1, bus.out_p5, bus.busy, bus.port_select, bus.tx_ready, bus.done, bus.underrun},
          9'b0_1_1_0_00_0_0_0);
    rst = 1'b0;

    tx_q = {8'hA5};
    g0 = got_q.size();
    frame_test("a5", 2'd2, -1);
    check("a5_oe_132", got_q.size() - g0, 132);

    tx_q = {8'h00, 8'hFF, 8'h3C};
    frame_test("three", 2'($urandom_range(0, 3)), -1);

    for (int f = 0; f < 3; f++) begin
      nb = $urandom_range(1, 3);
      tx_q.delete();
      for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom));
      frame_test($sformatf("rand%0d", f), 2'($urandom_range(0, 3)), -1);
    end

    tx_q.delete();
    frame_test("underrun", 2'd1, -1);

    tx_q = {8'($urandom)};
    frame_test("kick", 2'd2, 4 + 40 + 1 + 20);

    // Reset in the middle of the fifth DATA step of a two-byte frame.
    tx_q = {8'h5A, 8'hC3};
    r0 = ready_n; d0 = done_n; u0 = unr_n;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.port_in = 2'd1; drive_tx();
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    while (ready_n == r0 && n < BUDGET) begin drive_tx(); @(posedge clk); #1; n++; end
    check("rst_fetch_seen", ready_n - r0, 1);
    void'(tx_q.pop_front());
    drive_tx();
    repeat (4 * P + 1) @(posedge clk);
    #1;
    check("rst_pre_oe", bus.oe, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs",
          {bus.oe, bus.out_p1, bus.out_p5, bus.busy, bus.port_select, bus.tx_ready, bus.done, bus.underrun},
          9'b0_1_1_0_00_0_0_0);
    rst = 1'b0;
    tx_q.delete();
    drive_tx();
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_done", done_n - d0, 0);
    check("rst_no_underrun", unr_n - u0, 0);

    tx_q = {8'($urandom), 8'($urandom)};
    frame_test("post_rst", 2'd3, -1);

    check("ready_underrun_overlap", both_n, 0);

    n = 0;
    while (!(g_w[0].w_fin && g_w[1].w_fin) && n < 25000) begin @(posedge clk); n++; end
    check("width_runs_finished", {g_w[0].w_fin, g_w[1].w_fin}, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/maple_tx_sequencer.md
MAPLE_TX_SEQUENCER -- requirements
Module: maple_tx_sequencer

Interface
REQ-001 SHALL have parameter PHASE_CLKS, default 10: clk cycles per bus step (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  frame request pulse; sampled only in IDLE.
REQ-005 SHALL have port port_in  input  2  target port (0=A..3=D), sampled with start.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, MSB first.
REQ-007 SHALL have port tx_valid  input  1  tx_data/tx_last valid.
REQ-008 SHALL have port tx_last  input  1  current byte is the final byte of the frame.
REQ-009 SHALL have port tx_ready  output  1  one-cycle pulse; the byte is consumed when tx_valid&tx_ready.
REQ-010 SHALL have ports out_p1, out_p5  output  1 each  pin1/pin5 drive levels.
REQ-011 SHALL have port oe  output  1  bus drive enable.
REQ-012 SHALL have port port_select  output  2  selected physical port.
REQ-013 SHALL have ports busy, done, underrun  output  1 each  frame active / frame-complete pulse / aborted-frame pulse.

Function
REQ-014 SHALL hold every out_p1/out_p5/oe level for exactly PHASE_CLKS cycles per step, using an internal step counter reloaded at each step boundary.
REQ-015 SHALL implement states IDLE, LEAD, START, FETCH, DATA, END, HOLD.
REQ-016 IDLE: out_p1=1, out_p5=1, oe=0, busy=0; start=1 latches port_in into port_select and enters LEAD on the next cycle.
REQ-017 LEAD: 1 step of (p1,p5)=(1,1) with oe=1, then START.
REQ-018 START: 10 steps (p1,p5) = (0,1),(0,0),(0,1),(0,0),(0,1),(0,0),(0,1),(0,0),(0,1),(1,1), then FETCH.
REQ-019 FETCH: single cycle; if tx_valid=1, tx_ready pulses, tx_data/tx_last are latched, enter DATA; if tx_valid=0, underrun pulses and END is entered.
REQ-020 DATA: 16 steps, 2 per bit, bit index i=7..0; i odd: (1,b),(0,b); i even: (b,1),(b,0), where b=bit i.
REQ-021 After DATA: latched tx_last=1 -> END; otherwise -> FETCH.
REQ-022 END: 6 steps (p1,p5) = (1,0),(0,0),(1,0),(0,0),(1,0),(1,1), then HOLD.
REQ-023 HOLD: 1 step with (1,1), oe=0, port_select held; at exit, done pulses for 1 cycle and the state returns to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored with no effect.
REQ-025 port_select SHALL change only on an accepted start; it is held through HOLD and in IDLE.
REQ-026 tx_ready and underrun SHALL never be asserted in the same cycle; tx_ready SHALL never be asserted outside FETCH.
REQ-027 Byte-to-byte latency: the first DATA step begins on the cycle after FETCH; there is no idle step between bytes.
REQ-028 An underrun frame SHALL still emit the complete END+HOLD sequence and pulse done.

Reset
REQ-029 rst=1, including mid-frame, SHALL on the next edge force: IDLE, out_p1=1, out_p5=1, oe=0, port_select=0, tx_ready=0, busy=0, done=0, underrun=0, step counter=0.
REQ-030 A reset mid-frame SHALL not pulse done or underrun.

Verification
REQ-031 PHASE_CLKS=4, start with port_in=2, one byte 0xA5 tx_last=1 -> port_select=2; oe high for (1+10+16+6)*4=132 cycles; decoded pin bits 1,0,1,0,0,1,0,1; done pulses once.
REQ-032 Three bytes 0x00,0xFF,0x3C with tx_valid always 1 -> three tx_ready pulses, each exactly 64 cycles apart plus 1 FETCH cycle; bytes decode in order.
REQ-033 tx_valid=0 at the first FETCH -> underrun=1 for 1 cycle, no tx_ready, END follows immediately, done pulses.
REQ-034 start pulsed again mid-DATA with port_in=3 -> port_select unchanged and frame unaffected.
REQ-035 rst asserted during step 5 of DATA -> next cycle oe=0, p1=p5=1, busy=0; a subsequent start runs a clean frame.
REQ-036 Step-width check at PHASE_CLKS=2 and 255 -> every pin level persists exactly PHASE_CLKS cycles.
